// File: rtl/ws2812b_frame_streamer.sv
// Double-buffered WS2812B pixel store: assembles G/R/B bytes into a write bank
// and streams the display bank one 24-bit LED word at a time on each frame tick.
module ws2812b_frame_streamer #(
   parameter int unsigned LEDCOUNT      = 36,
   parameter int unsigned BYTES_PER_LED = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        byte_first,
   input  logic        frame_tick,
   input  logic        bitstream_read,
   output logic        bitstream_available,
   output logic [23:0] bitstream,
   output logic        busy,
   output logic        frame_done,
   output logic        overflow
);

   localparam int unsigned FRAME_BYTES = BYTES_PER_LED * LEDCOUNT;
   localparam int unsigned IDX_W       = $clog2(FRAME_BYTES + 1);
   localparam int unsigned LED_W       = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1;
   localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_BYTES);
   localparam logic [LED_W-1:0] LAST_LED  = LED_W'(LEDCOUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Pixel banks; contents are never reset, display_valid_q gates their use
   logic [23:0] bank0_mem [LEDCOUNT];
   logic [23:0] bank1_mem [LEDCOUNT];

   logic             bank_q;
   logic             display_valid_q;
   logic             frame_pending_q;
   logic             frame_pending_d;
   logic [IDX_W-1:0] byte_idx_q;
   logic [1:0]       phase_q;
   logic [LED_W-1:0] wr_led_q;
   logic [7:0]       g_q;
   logic [7:0]       r_q;
   logic [LED_W-1:0] led_idx_q;
   logic [LED_W-1:0] led_idx_d;
   logic [23:0]      bitstream_d;
   logic             available_d;
   logic             busy_d;
   logic             frame_done_d;

   logic             start_c;
   logic             swap_c;
   logic             last_led_c;
   logic             byte_start_c;
   logic             byte_store_c;
   logic             byte_drop_c;
   logic             mem_we_c;
   logic             frame_complete_c;
   logic [23:0]      rd_word_c;

   assign start_c      = (state_q == ST_IDLE) & frame_tick & (frame_pending_q | display_valid_q);
   assign swap_c       = (state_q == ST_IDLE) & frame_tick & frame_pending_q;
   assign last_led_c   = (led_idx_q == LAST_LED);
   assign byte_start_c = byte_valid & byte_first;
   assign byte_store_c = byte_valid & ~byte_first & (byte_idx_q != FRAME_END);
   assign byte_drop_c  = byte_valid & ~byte_first & (byte_idx_q == FRAME_END);
   assign mem_we_c     = byte_store_c & (phase_q == 2'd2);
   assign frame_complete_c = byte_store_c & ((byte_idx_q + IDX_W'(1)) == FRAME_END);
   assign rd_word_c    = bank_q ? bank1_mem[led_idx_q] : bank0_mem[led_idx_q];

   // Writes go to the bank opposite the display bank, so streaming is never disturbed
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         if (bank_q) begin
            bank0_mem[wr_led_q] <= {g_q, r_q, byte_data};
         end else begin
            bank1_mem[wr_led_q] <= {g_q, r_q, byte_data};
         end
      end
   end

   always_comb begin
      frame_pending_d = frame_pending_q;
      if (frame_complete_c) begin
         frame_pending_d = 1'b1;
      end
      if (swap_c || byte_start_c) begin
         frame_pending_d = 1'b0;
      end
   end

   // Byte write pointer, colour assembly and overflow tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx_q      <= '0;
         phase_q         <= 2'd0;
         wr_led_q        <= '0;
         g_q             <= 8'd0;
         r_q             <= 8'd0;
         overflow        <= 1'b0;
         frame_pending_q <= 1'b0;
      end else begin
         frame_pending_q <= frame_pending_d;
         if (byte_start_c) begin
            byte_idx_q <= IDX_W'(1);
            phase_q    <= 2'd1;
            wr_led_q   <= '0;
            g_q        <= byte_data;
            overflow   <= 1'b0;
         end else if (byte_drop_c) begin
            overflow <= 1'b1;
         end else if (byte_store_c) begin
            byte_idx_q <= byte_idx_q + IDX_W'(1);
            unique case (phase_q)
               2'd0: begin
                  g_q     <= byte_data;
                  phase_q <= 2'd1;
               end
               2'd1: begin
                  r_q     <= byte_data;
                  phase_q <= 2'd2;
               end
               default: begin
                  phase_q  <= 2'd0;
                  wr_led_q <= wr_led_q + LED_W'(1);
               end
            endcase
         end
      end
   end

   // Streaming FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Streaming FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (bitstream_read) begin
               state_d = last_led_c ? ST_IDLE : ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Streaming FSM outputs, computed one cycle ahead and registered below
   always_comb begin
      led_idx_d    = led_idx_q;
      bitstream_d  = bitstream;
      frame_done_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               led_idx_d = '0;
            end
         end
         ST_FETCH: begin
            bitstream_d = rd_word_c;
         end
         ST_PRESENT: begin
            if (bitstream_read) begin
               if (last_led_c) begin
                  frame_done_d = 1'b1;
               end else begin
                  led_idx_d = led_idx_q + LED_W'(1);
               end
            end
         end
         default: begin
            led_idx_d = '0;
         end
      endcase
      available_d = (state_d == ST_PRESENT);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_idx_q           <= '0;
         bitstream           <= 24'd0;
         bitstream_available <= 1'b0;
         busy                <= 1'b0;
         frame_done          <= 1'b0;
         bank_q              <= 1'b0;
         display_valid_q     <= 1'b0;
      end else begin
         led_idx_q           <= led_idx_d;
         bitstream           <= bitstream_d;
         bitstream_available <= available_d;
         busy                <= busy_d;
         frame_done          <= frame_done_d;
         if (swap_c) begin
            bank_q          <= ~bank_q;
            display_valid_q <= 1'b1;
         end
      end
   end

endmodule
